cdb_slot_scheduler: RTL and testbench
=====================================

// Module: cdb_slot_scheduler
// PURPOSE
// Parametrised issue arbiter for the common data bus (CDB). Serves NUM_FU execution units, each with a fixed latency.
// Reserves the CDB slot a unit's result will occupy, so no two results ever collide on the bus.
// Units of equal latency contend through round-robin. Sits between the reservation stations (issue_rdy) and the FUs (issue_grant).
// Also reports which unit owns the CDB in each cycle.
// PARAMETERS
// NUM_FU   4                 number of execution units (>=2)
// MAX_LAT  8                 depth of slot-reservation window; every FU_LAT[i] in 1..MAX_LAT
// FU_LAT   {8'd1,8'd1,8'd4,8'd6}  packed [NUM_FU-1:0][7:0] latency per unit; idx0=div(6), idx1=mul(4), idx2=int(1), idx3=ls(1)
// ID_W     $clog2(NUM_FU)    width of unit id
// PORTS
// clk            in   1        clock
// rst            in   1        synchronous, active-high reset
// issue_rdy      in   NUM_FU   unit i has an instruction ready to issue
// cdb_stall      in   1        suppress all new grants this cycle
// issue_grant    out  NUM_FU   unit i issues this cycle (combinational from state + issue_rdy)
// cdb_owner_vld  out  1        a reserved result occupies the CDB this cycle
// cdb_owner_id   out  ID_W     unit owning the CDB this cycle (0 when !cdb_owner_vld)
// rr_ptr_o       out  ID_W     current round-robin start index (debug / coverage)
// BEHAVIOUR
// - Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
// - State:
//   - slot_q[0..MAX_LAT-1]: reserved bit plus owner id; entry k means the CDB is reserved k cycles from now.
//   - rr_ptr: round-robin start index.
// - Reset: slot_q cleared, rr_ptr=0.
//   - While rst is high, issue_grant='0 and cdb_owner_vld=0 (cdb_owner_id=0).
//   - Reset mid-flight drops all reservations; no owner_vld is ever produced for pre-reset grants.
// - Outputs: cdb_owner_vld=slot_q[0].vld and cdb_owner_id=slot_q[0].id, both registered.
// - Free check: unit i with L=FU_LAT[i] is eligible iff issue_rdy[i], !cdb_stall, and slot_q[L] is free.
//   - slot_q[MAX_LAT] is treated as always free.
// - Grant scan: units are scanned in order rr_ptr, rr_ptr+1, ... (mod NUM_FU).
//   - An eligible unit is granted unless an earlier-scanned unit of the same latency was already granted this cycle.
//   - Result: at most one grant per distinct latency per cycle. Units of different latency may be granted together.
// - Latency: a grant in cycle t gives cdb_owner_vld=1 with cdb_owner_id=i in cycle t+L exactly.
// - Next state: slot_d[k]=slot_q[k+1] for k<MAX_LAT-1, and slot_d[MAX_LAT-1]=free.
//   - Then each grant of unit i sets slot_d[L-1]={1,i}.
// - Round-robin update: if any eligible unit was denied only by a same-latency collision, rr_ptr <= (g+1) mod NUM_FU.
//   - g is the last granted unit in scan order.
//   - Otherwise rr_ptr holds.
// - Fairness: a unit holding issue_rdy continuously is granted within NUM_FU cycles, provided its slot is not blocked by longer-latency reservations.
// - cdb_stall: blocks new grants only. Existing reservations keep shifting and are delivered on schedule. rr_ptr holds.
// - Handshake: issue_rdy may drop in any cycle with no penalty. A grant is a single-cycle pulse. The FU must accept it unconditionally.
// - Invariant (assert): no two grants in one cycle target the same slot. slot_q[k].vld implies slot_q[k].id < NUM_FU.
// - Elaboration check: any FU_LAT[i]==0 or FU_LAT[i]>MAX_LAT triggers $error.
// STRUCTURE
// - Package cdb_sched_pkg holds:
//   - typedef slot_t {logic vld; logic [ID_W-1:0] id;}
//   - function rr_next(ptr, idx, n)
//   - localparam LAT_W=8
// - Sub-module rr_grant_scan (combinational rotate-scan with same-latency masking) takes issue_rdy, the free vector, rr_ptr and FU_LAT.
//   - It returns the grant vector and the collision flag.
// - Top level holds slot_q, rr_ptr, the shift/reserve logic and the assertions.
// TESTING (defaults: div=6, mul=4, int=1, ls=1)
// - int rdy only at t0 -> issue_grant=4'b0100 at t0; owner_vld=1, id=2 at t1.
// - int+ls rdy held t0..t3 -> grants alternate 2,3,2,3; never both in one cycle; one owner per cycle t1..t4.
// - mul rdy t0, int rdy t3..t4 -> mul granted t0; int denied t3 (slot t4 taken), granted t4; owners t4=1, t5=2.
// - div rdy t0, mul rdy t2..t3 -> both target t6; mul denied t2, granted t3; owner t6=0, t7=1.
// - div granted t0, cdb_stall=1 t1..t7 with all rdy high -> no grants t1..t7; owner_vld=1, id=0 still at t6.
// - div granted t0, rst=1 at t2 -> owner_vld=0 t3..t8; rr_ptr=0; normal grants resume the cycle after rst falls.

Source files
------------

// File: rtl/cdb_sched_pkg.sv
// Shared types and helpers for the CDB slot scheduler: slot entry layout and
// round-robin index arithmetic.
package cdb_sched_pkg;

  localparam int LAT_W    = 8;
  // Wide enough for any practical unit count; the top truncates to ID_W.
  localparam int ID_MAX_W = 8;

  typedef struct packed {
    logic                vld;
    logic [ID_MAX_W-1:0] id;
  } slot_t;

  function automatic int rr_next(input int ptr, input int idx, input int n);
    return (ptr + idx) % n;
  endfunction

endpackage

// File: rtl/cdb_slot_scheduler_scan.sv
// Rotate-scan grant logic: among eligible units, the first of each latency in
// scan order (starting at rr_ptr) wins; later same-latency units collide.
module rr_grant_scan
  import cdb_sched_pkg::*;
#(
  parameter int                             NUM_FU = 4,
  parameter logic [NUM_FU-1:0][LAT_W-1:0]   FU_LAT = '0,
  parameter int                             ID_W   = 2
) (
  input  logic [NUM_FU-1:0] issue_rdy,
  input  logic [NUM_FU-1:0] free,
  input  logic [ID_W-1:0]   rr_ptr,
  output logic [NUM_FU-1:0] grant,
  output logic [ID_W-1:0]   last_g,
  output logic              coll
);

  logic [NUM_FU-1:0] elig;
  int                pos [NUM_FU];
  int                best;
  logic              blocked;

  assign elig = issue_rdy & free;

  // Scan position of each unit relative to the round-robin start.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++)
      pos[i] = rr_next(i, NUM_FU - int'(rr_ptr), NUM_FU);
  end

  always_comb begin
    grant   = '0;
    coll    = 1'b0;
    last_g  = '0;
    best    = -1;
    blocked = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < NUM_FU; j++)
        if (j != i && FU_LAT[j] == FU_LAT[i] && elig[j] && pos[j] < pos[i])
          blocked = 1'b1;
      if (elig[i]) begin
        if (blocked) begin
          coll = 1'b1;
        end else begin
          grant[i] = 1'b1;
          if (pos[i] > best) begin
            best   = pos[i];
            last_g = ID_W'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/cdb_slot_scheduler.sv
// CDB issue arbiter: reserves the bus slot each fixed-latency result lands in
// and reports the owner of the bus every cycle.
module cdb_slot_scheduler
  import cdb_sched_pkg::*;
#(
  parameter int                           NUM_FU  = 4,
  parameter int                           MAX_LAT = 8,
  parameter logic [NUM_FU-1:0][LAT_W-1:0] FU_LAT  = {8'd1, 8'd1, 8'd4, 8'd6},
  parameter int                           ID_W    = $clog2(NUM_FU)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_FU-1:0] issue_rdy,
  input  logic              cdb_stall,
  output logic [NUM_FU-1:0] issue_grant,
  output logic              cdb_owner_vld,
  output logic [ID_W-1:0]   cdb_owner_id,
  output logic [ID_W-1:0]   rr_ptr_o
);

  slot_t             slot_q [MAX_LAT];
  slot_t             slot_d [MAX_LAT];
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   last_g;
  logic [NUM_FU-1:0] free;
  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] grant;
  logic              coll;

  // A unit of latency L lands its result where slot_q[L] sits now.
  for (genvar i = 0; i < NUM_FU; i++) begin : g_free
    localparam int L = int'(FU_LAT[i]);
    if (L == 0 || L > MAX_LAT) begin : g_bad
      $error("cdb_slot_scheduler: FU_LAT[%0d]=%0d outside 1..%0d", i, L, MAX_LAT);
      assign free[i] = 1'b0;
    end else if (L == MAX_LAT) begin : g_edge
      assign free[i] = 1'b1;
    end else begin : g_chk
      assign free[i] = ~slot_q[L].vld;
    end
  end

  assign req = issue_rdy & {NUM_FU{~rst & ~cdb_stall}};

  rr_grant_scan #(
    .NUM_FU (NUM_FU),
    .FU_LAT (FU_LAT),
    .ID_W   (ID_W)
  ) u_scan (
    .issue_rdy (req),
    .free      (free),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .last_g    (last_g),
    .coll      (coll)
  );

  always_comb begin
    for (int k = 0; k < MAX_LAT - 1; k++) slot_d[k] = slot_q[k+1];
    slot_d[MAX_LAT-1] = '0;
    for (int i = 0; i < NUM_FU; i++)
      if (grant[i] && FU_LAT[i] != 0 && int'(FU_LAT[i]) <= MAX_LAT)
        slot_d[int'(FU_LAT[i]) - 1] = '{vld: 1'b1, id: ID_MAX_W'(i)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MAX_LAT; k++) slot_q[k] <= '0;
      rr_ptr_q <= '0;
    end else begin
      slot_q <= slot_d;
      if (coll) rr_ptr_q <= ID_W'(rr_next(int'(last_g), 1, NUM_FU));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FU; i++)
        for (int j = i + 1; j < NUM_FU; j++)
          if (FU_LAT[i] == FU_LAT[j]) assert (!(grant[i] && grant[j]));
      for (int k = 0; k < MAX_LAT; k++)
        assert (!slot_q[k].vld || int'(slot_q[k].id) < NUM_FU);
    end
  end

  // Masked during reset so no stale reservation is seen while rst is high.
  assign issue_grant   = grant;
  assign cdb_owner_vld = slot_q[0].vld & ~rst;
  assign cdb_owner_id  = rst ? '0 : ID_W'(slot_q[0].id);
  assign rr_ptr_o      = rr_ptr_q;

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Directed-vector bench for cdb_slot_scheduler with default latencies
// (unit0=6, unit1=4, unit2=1, unit3=1).
module tb_cdb_slot_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] issue_rdy = '0;
  logic       cdb_stall = 1'b0;
  logic [3:0] issue_grant;
  logic       cdb_owner_vld;
  logic [1:0] cdb_owner_id;
  logic [1:0] rr_ptr_o;

  int n_chk = 0;
  int n_err = 0;

  cdb_slot_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .issue_rdy     (issue_rdy),
    .cdb_stall     (cdb_stall),
    .issue_grant   (issue_grant),
    .cdb_owner_vld (cdb_owner_vld),
    .cdb_owner_id  (cdb_owner_id),
    .rr_ptr_o      (rr_ptr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0d exp %0d", tag, $time, got, exp);
    end
  endtask

  // One cycle: drive just after the edge, check mid-cycle.
  task automatic cyc(input string tag, input logic r, input logic [3:0] rdy,
                     input logic st, input logic [3:0] eg, input logic ev,
                     input int eid, input int err);
    @(posedge clk);
    #1;
    rst = r; issue_rdy = rdy; cdb_stall = st;
    @(negedge clk);
    chk({tag, ".grant"}, int'(issue_grant), int'(eg));
    chk({tag, ".vld"}, int'(cdb_owner_vld), int'(ev));
    chk({tag, ".id"}, int'(cdb_owner_id), eid);
    chk({tag, ".rr"}, int'(rr_ptr_o), err);
  endtask

  initial begin
    // reset with everything requesting
    cyc("rst0", 1, 4'b1111, 0, 4'b0000, 0, 0, 0);
    cyc("rst1", 1, 4'b1111, 0, 4'b0000, 0, 0, 0);

    // single int issue
    cyc("s1t0", 0, 4'b0100, 0, 4'b0100, 0, 0, 0);
    cyc("s1t1", 0, 4'b0000, 0, 4'b0000, 1, 2, 0);
    cyc("s1t2", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);

    // int+ls alternate via round-robin
    cyc("s2t0", 0, 4'b1100, 0, 4'b0100, 0, 0, 0);
    cyc("s2t1", 0, 4'b1100, 0, 4'b1000, 1, 2, 3);
    cyc("s2t2", 0, 4'b1100, 0, 4'b0100, 1, 3, 0);
    cyc("s2t3", 0, 4'b1100, 0, 4'b1000, 1, 2, 3);
    cyc("s2t4", 0, 4'b0000, 0, 4'b0000, 1, 3, 0);
    cyc("s2t5", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);

    // mul reservation blocks a later int
    cyc("s3t0", 0, 4'b0010, 0, 4'b0010, 0, 0, 0);
    cyc("s3t1", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    cyc("s3t2", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    cyc("s3t3", 0, 4'b0100, 0, 4'b0000, 0, 0, 0);
    cyc("s3t4", 0, 4'b0100, 0, 4'b0100, 1, 1, 0);
    cyc("s3t5", 0, 4'b0000, 0, 4'b0000, 1, 2, 0);
    cyc("s3t6", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);

    // div reservation blocks mul targeting the same slot
    cyc("s4t0", 0, 4'b0001, 0, 4'b0001, 0, 0, 0);
    cyc("s4t1", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    cyc("s4t2", 0, 4'b0010, 0, 4'b0000, 0, 0, 0);
    cyc("s4t3", 0, 4'b0010, 0, 4'b0010, 0, 0, 0);
    cyc("s4t4", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    cyc("s4t5", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    cyc("s4t6", 0, 4'b0000, 0, 4'b0000, 1, 0, 0);
    cyc("s4t7", 0, 4'b0000, 0, 4'b0000, 1, 1, 0);
    cyc("s4t8", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);

    // stall blocks grants but not delivery
    cyc("s5t0", 0, 4'b0001, 0, 4'b0001, 0, 0, 0);
    for (int t = 1; t <= 7; t++)
      cyc($sformatf("s5t%0d", t), 0, 4'b1111, 1, 4'b0000, (t == 6), 0, 0);
    cyc("s5t8", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);

    // reset mid-flight drops the div reservation
    cyc("s6t0", 0, 4'b0001, 0, 4'b0001, 0, 0, 0);
    cyc("s6t1", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    cyc("s6t2", 1, 4'b1111, 0, 4'b0000, 0, 0, 0);
    cyc("s6t3", 0, 4'b0100, 0, 4'b0100, 0, 0, 0);
    cyc("s6t4", 0, 4'b0000, 0, 4'b0000, 1, 2, 0);
    for (int t = 5; t <= 8; t++)
      cyc($sformatf("s6t%0d", t), 0, 4'b0000, 0, 4'b0000, 0, 0, 0);

    // all units at once: distinct latencies issue together
    cyc("s7t0", 0, 4'b1111, 0, 4'b0111, 0, 0, 0);
    cyc("s7t1", 0, 4'b1111, 0, 4'b1011, 1, 2, 3);
    cyc("s7t2", 0, 4'b0000, 0, 4'b0000, 1, 3, 2);
    cyc("s7t3", 0, 4'b0000, 0, 4'b0000, 0, 0, 2);
    cyc("s7t4", 0, 4'b0000, 0, 4'b0000, 1, 1, 2);
    cyc("s7t5", 0, 4'b0000, 0, 4'b0000, 1, 1, 2);
    cyc("s7t6", 0, 4'b0000, 0, 4'b0000, 1, 0, 2);
    cyc("s7t7", 0, 4'b0000, 0, 4'b0000, 1, 0, 2);
    cyc("s7t8", 0, 4'b0000, 0, 4'b0000, 0, 0, 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
